seq_mul_unit: RTL and testbench
===============================

Name: seq_mul_unit

Overview:
- Parametrised multicycle multiplier serving the MUL, UMULL and SMULL operations that the decoder tags with ALUControl codes 101, 110 and 111.
- Replaces single-cycle combinational multiply so that cycle time is not set by a WIDTH x WIDTH array.
- The main FSM starts it, stalls on busy, and writes result_lo/result_hi (long ops) on done.
- Generalised over operand width and bits retired per cycle.

Parameters:
WIDTH, 32, operand width in bits; result is 2*WIDTH.
STEP, 1, multiplier bits retired per CALC cycle; legal values 1, 2, 4; WIDTH must be divisible by STEP.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous reset, active-low (0 = reset)
start  input  1  request; sampled only in IDLE
op  input  3  101 MUL, 110 UMULL, 111 SMULL; any other code is illegal
a  input  WIDTH  multiplicand (Rn/Rm per decoder)
b  input  WIDTH  multiplier
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; results valid from this cycle on
result_lo  output  WIDTH  low half of product
result_hi  output  WIDTH  high half; 0 for MUL
long_out  output  1  1 when the completed op was UMULL/SMULL
flag_n  output  1  negative flag of completed op
flag_z  output  1  zero flag of completed op
illegal  output  1  completed request carried an illegal op

Behaviour:
- Reset (reset=0, async, any state): state=IDLE; all outputs and internal registers 0.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE, start=1 at a rising edge:
  - Latch op and operands. For SMULL, latch |a| and |b| and neg = a[W-1]^b[W-1]; otherwise neg=0.
  - Clear the 2*WIDTH accumulator; iteration counter = WIDTH/STEP.
  - Go to CALC, or directly to DONE if op is illegal.
- CALC, each cycle:
  - Take the low STEP bits of the multiplier register; add (bits * multiplicand) into the accumulator, aligned at the current position (shift-add).
  - Shift the multiplier right by STEP; decrement the counter.
  - When the counter reaches 1, go to FIX. CALC occupies exactly WIDTH/STEP cycles.
- FIX (1 cycle): if neg, take the two's complement of the 2*WIDTH accumulator; go to DONE.
- DONE (1 cycle): done=1; go to IDLE.
- Output registers load on entry to DONE and hold until the next accepted start reaches DONE, or until reset.
  - MUL: result_lo = acc[W-1:0]; result_hi = 0; long_out=0; flag_n = result_lo[W-1]; flag_z = (result_lo==0).
  - UMULL/SMULL: {result_hi,result_lo} = acc; long_out=1; flag_n = result_hi[W-1]; flag_z = (full 2W result == 0).
  - Illegal op: results 0, long_out=0, flags 0, illegal=1. illegal clears on the next accepted start.
  - No C/V flags are produced; the decoder leaves them unaffected for multiplies.
- Latency: with start sampled at edge 0, done is high in the cycle after edge WIDTH/STEP+2 (34 for WIDTH=32, STEP=1; 10 for STEP=4). An illegal op gives done after edge 1.
- start while busy (including the DONE cycle) is ignored, not queued; a, b and op may change freely while busy.
- Back-to-back: start asserted in the first IDLE cycle after done is accepted.
- SMULL magnitude of the most negative value: |0x80..0| is treated as unsigned 2^(W-1); the result stays exact.
- Reset mid-operation aborts with no done pulse.

Test Plan:
- MUL a=7, b=6 -> done at the latency above; result_lo=42, result_hi=0, long_out=0, n=0, z=0.
- UMULL a=b=0xFFFFFFFF -> result_hi=0xFFFFFFFE, result_lo=0x00000001, long_out=1, n=1, z=0. Also a=0, b=0x1234 -> all zero, z=1.
- SMULL a=0xFFFFFFFF (-1), b=1 -> hi=lo=0xFFFFFFFF, n=1. SMULL a=b=0x80000000 -> hi=0x40000000, lo=0, n=0.
- start pulsed again mid-CALC with different operands -> ignored; exactly one done, with the first result. A second start in the cycle after done -> accepted.
- op=3'b010 -> done after edge 1, illegal=1, results 0. A following legal MUL clears illegal.
- reset low during CALC -> immediate IDLE, outputs 0, no done. Repeat the UMULL case with STEP=2 and STEP=4 and check latencies of 18 and 10.

Source files
------------

// File: rtl/seq_mul_unit.sv
// Multicycle shift-add multiplier for MUL, UMULL and SMULL.
// Retires STEP multiplier bits per CALC cycle and fixes the sign once at the end.
module seq_mul_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             long_out,
    output logic             flag_n,
    output logic             flag_z,
    output logic             illegal
);

    localparam int ITERS = WIDTH / STEP;
    localparam int CW    = $clog2(ITERS + 1);
    localparam logic [CW-1:0] ITERS_CNT = CW'(ITERS);
    localparam logic [2:0] OP_MUL   = 3'b101;
    localparam logic [2:0] OP_UMULL = 3'b110;
    localparam logic [2:0] OP_SMULL = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t             state, state_next;
    logic [2*WIDTH-1:0] acc, mcand, partial, fixed;
    logic [WIDTH-1:0]   mplier, a_mag, b_mag;
    logic [CW-1:0]      count;
    logic               neg, long_q;
    logic               op_legal, accept;

    assign op_legal = (op == OP_MUL) || (op == OP_UMULL) || (op == OP_SMULL);
    assign accept   = (state == S_IDLE) && start;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

    // Signed operands become magnitudes; |most negative| reads as unsigned 2^(W-1).
    assign a_mag = ((op == OP_SMULL) && a[WIDTH-1]) ? -a : a;
    assign b_mag = ((op == OP_SMULL) && b[WIDTH-1]) ? -b : b;
    assign fixed = neg ? -acc : acc;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        partial = '0;
        for (int j = 0; j < STEP; j++) begin
            if (mplier[j]) partial = partial + (mcand << j);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = op_legal ? S_CALC : S_DONE;
            S_CALC:  if (count == CW'(1)) state_next = S_FIX;
            S_FIX:   state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            count     <= '0;
            neg       <= 1'b0;
            long_q    <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
            long_out  <= 1'b0;
            flag_n    <= 1'b0;
            flag_z    <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            if (accept) begin
                mcand   <= {{WIDTH{1'b0}}, a_mag};
                mplier  <= b_mag;
                acc     <= '0;
                count   <= ITERS_CNT;
                neg     <= (op == OP_SMULL) && (a[WIDTH-1] ^ b[WIDTH-1]);
                long_q  <= (op == OP_UMULL) || (op == OP_SMULL);
                illegal <= !op_legal;
                // An illegal request enters DONE on this edge with zeroed results.
                if (!op_legal) begin
                    result_lo <= '0;
                    result_hi <= '0;
                    long_out  <= 1'b0;
                    flag_n    <= 1'b0;
                    flag_z    <= 1'b0;
                end
            end

            if (state == S_CALC) begin
                acc    <= acc + partial;
                mcand  <= mcand << STEP;
                mplier <= mplier >> STEP;
                count  <= count - CW'(1);
            end

            if (state == S_FIX) begin
                acc <= fixed;
                if (long_q) begin
                    result_hi <= fixed[2*WIDTH-1:WIDTH];
                    result_lo <= fixed[WIDTH-1:0];
                    long_out  <= 1'b1;
                    flag_n    <= fixed[2*WIDTH-1];
                    flag_z    <= (fixed == '0);
                end else begin
                    result_hi <= '0;
                    result_lo <= fixed[WIDTH-1:0];
                    long_out  <= 1'b0;
                    flag_n    <= fixed[WIDTH-1];
                    flag_z    <= (fixed[WIDTH-1:0] == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_mul_unit.sv
// Bench for seq_mul_unit: three instances (STEP 1, 2, 4) checked against an
// arithmetic reference model, a hand-computed vector table and corner sequences.
module tb_seq_mul_unit;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, lo, hi;
        logic        lng, n, z, ill;
    } vec_t;

    logic        clk, reset;
    logic [2:0]  start_v;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [2:0]  busy_v, done_v, long_v, n_v, z_v, ill_v;
    logic [31:0] lo_v [3];
    logic [31:0] hi_v [3];

    int vectors = 0;
    int miscompares = 0;
    int done_cnt [3] = '{0, 0, 0};
    int step_of  [3] = '{1, 2, 4};

    seq_mul_unit #(.WIDTH(32), .STEP(1)) u_mul1 (
        .clk(clk), .reset(reset), .start(start_v[0]), .op(op), .a(a), .b(b),
        .busy(busy_v[0]), .done(done_v[0]), .result_lo(lo_v[0]), .result_hi(hi_v[0]),
        .long_out(long_v[0]), .flag_n(n_v[0]), .flag_z(z_v[0]), .illegal(ill_v[0]));

    seq_mul_unit #(.WIDTH(32), .STEP(2)) u_mul2 (
        .clk(clk), .reset(reset), .start(start_v[1]), .op(op), .a(a), .b(b),
        .busy(busy_v[1]), .done(done_v[1]), .result_lo(lo_v[1]), .result_hi(hi_v[1]),
        .long_out(long_v[1]), .flag_n(n_v[1]), .flag_z(z_v[1]), .illegal(ill_v[1]));

    seq_mul_unit #(.WIDTH(32), .STEP(4)) u_mul4 (
        .clk(clk), .reset(reset), .start(start_v[2]), .op(op), .a(a), .b(b),
        .busy(busy_v[2]), .done(done_v[2]), .result_lo(lo_v[2]), .result_hi(hi_v[2]),
        .long_out(long_v[2]), .flag_n(n_v[2]), .flag_z(z_v[2]), .illegal(ill_v[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (done_v[0]) done_cnt[0]++;
        if (done_v[1]) done_cnt[1]++;
        if (done_v[2]) done_cnt[2]++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [2:0] o, logic [31:0] x, logic [31:0] y, logic [31:0] lo,
                                logic [31:0] hi, logic lng, logic n, logic z, logic ill);
        vec_t r;
        r.op = o; r.a = x; r.b = y; r.lo = lo; r.hi = hi;
        r.lng = lng; r.n = n; r.z = z; r.ill = ill;
        return r;
    endfunction

    // Reference: plain 64-bit arithmetic on the architectural operation.
    function automatic vec_t model(logic [2:0] o, logic [31:0] x, logic [31:0] y);
        vec_t r;
        logic [63:0] p;
        r = mk(o, x, y, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        case (o)
            3'b101: begin
                p = {32'd0, x} * {32'd0, y};
                r.lo = p[31:0];
                r.n = p[31];
                r.z = (p[31:0] == 32'd0);
            end
            3'b110, 3'b111: begin
                if (o == 3'b110) p = {32'd0, x} * {32'd0, y};
                else             p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
                r.lo = p[31:0];
                r.hi = p[63:32];
                r.lng = 1'b1;
                r.n = p[63];
                r.z = (p == 64'd0);
            end
            default: r.ill = 1'b1;
        endcase
        return r;
    endfunction

    task automatic wait_done(input int k, inout int lat);
        while (!done_v[k] && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Starts one op on instance k, scrambles inputs while busy, returns edges to done
    // (accepting edge counts as 1) and leaves the bench in the following IDLE cycle.
    task automatic run_op(input int k, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, output int lat);
        @(negedge clk);
        op = o; a = x; b = y; start_v[k] = 1'b1;
        @(posedge clk);
        #1;
        start_v[k] = 1'b0;
        op = 3'($urandom); a = $urandom; b = $urandom;
        lat = 1;
        wait_done(k, lat);
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input int k, input string tag, input vec_t e, input int lat);
        int exp_lat;
        exp_lat = e.ill ? 1 : 32 / step_of[k] + 2;
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " lo"}, 64'(lo_v[k]), 64'(e.lo));
        check({tag, " hi"}, 64'(hi_v[k]), 64'(e.hi));
        check({tag, " long/n/z/ill"}, {60'd0, long_v[k], n_v[k], z_v[k], ill_v[k]},
              {60'd0, e.lng, e.n, e.z, e.ill});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vec_t tbl [9];
        vec_t e;
        int lat, d0, r;
        logic [2:0] o;
        logic [31:0] x, y;

        tbl[0] = mk(3'b101, 32'd7, 32'd6, 32'd42, 32'd0, 0, 0, 0, 0);
        tbl[1] = mk(3'b110, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1, 1, 0, 0);
        tbl[2] = mk(3'b110, 32'd0, 32'h1234, 32'd0, 32'd0, 1, 0, 1, 0);
        tbl[3] = mk(3'b111, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 0, 0);
        tbl[4] = mk(3'b111, 32'h80000000, 32'h80000000, 32'd0, 32'h40000000, 1, 0, 0, 0);
        tbl[5] = mk(3'b010, 32'd5, 32'd3, 32'd0, 32'd0, 0, 0, 0, 1);
        tbl[6] = mk(3'b101, 32'h00010000, 32'h00010000, 32'd0, 32'd0, 0, 0, 1, 0);
        tbl[7] = mk(3'b111, 32'h80000000, 32'd1, 32'h80000000, 32'hFFFFFFFF, 1, 1, 0, 0);
        tbl[8] = mk(3'b101, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'd0, 0, 1, 0, 0);

        reset = 1'b0; start_v = 3'b000; op = 3'b000; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset lo[%0d]", k), 64'(lo_v[k]), 64'd0);
            check($sformatf("reset hi[%0d]", k), 64'(hi_v[k]), 64'd0);
            check($sformatf("reset status[%0d]", k),
                  {58'd0, busy_v[k], done_v[k], long_v[k], n_v[k], z_v[k], ill_v[k]}, 64'd0);
        end
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_op(0, tbl[i].op, tbl[i].a, tbl[i].b, lat);
            check_result(0, $sformatf("table[%0d]", i), tbl[i], lat);
        end

        // illegal clears as soon as the next legal start is accepted
        run_op(0, 3'b000, 32'd9, 32'd9, lat);
        check("illegal set", 64'(ill_v[0]), 64'd1);
        @(negedge clk);
        op = 3'b101; a = 32'd2; b = 32'd3; start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        check("illegal cleared on accept", {62'd0, busy_v[0], ill_v[0]}, 64'b10);
        lat = 1;
        wait_done(0, lat);
        check("mul after illegal lo", 64'(lo_v[0]), 64'd6);
        @(posedge clk);
        #1;

        // start during CALC is ignored; then back-to-back start in first IDLE cycle
        d0 = done_cnt[0];
        @(negedge clk);
        op = 3'b101; a = 32'd7; b = 32'd6; start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        op = 3'b110; a = 32'hFFFFFFFF; b = 32'd3; start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        lat = 7;
        wait_done(0, lat);
        check("ignored start latency", 64'(lat), 64'd34);
        check("ignored start lo", 64'(lo_v[0]), 64'd42);
        check("ignored start hi/long", {63'd0, long_v[0]} | 64'(hi_v[0]), 64'd0);
        @(posedge clk);
        #1;
        check("idle after done", 64'(busy_v[0]), 64'd0);
        op = 3'b101; a = 32'd9; b = 32'd9; start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        check("back-to-back accepted", 64'(busy_v[0]), 64'd1);
        lat = 1;
        wait_done(0, lat);
        check("back-to-back latency", 64'(lat), 64'd34);
        check("back-to-back lo", 64'(lo_v[0]), 64'd81);
        repeat (40) @(posedge clk);
        #1;
        check("done pulse count", 64'(done_cnt[0] - d0), 64'd2);

        // reset mid-CALC aborts without done and clears outputs
        @(negedge clk);
        op = 3'b110; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        d0 = done_cnt[0];
        reset = 1'b0;
        #1;
        check("abort lo", 64'(lo_v[0]), 64'd0);
        check("abort status", {58'd0, busy_v[0], done_v[0], long_v[0], n_v[0], z_v[0], ill_v[0]},
              64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("abort no done", 64'(done_cnt[0] - d0), 64'd0);

        // wider steps on the UMULL corner
        run_op(1, tbl[1].op, tbl[1].a, tbl[1].b, lat);
        check_result(1, "umull step2", tbl[1], lat);
        run_op(2, tbl[1].op, tbl[1].a, tbl[1].b, lat);
        check_result(2, "umull step4", tbl[1], lat);

        for (int i = 0; i < 45; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      o = 3'($urandom_range(0, 4));
            else if (r < 4)  o = 3'b101;
            else if (r < 7)  o = 3'b110;
            else             o = 3'b111;
            x = pick();
            y = pick();
            run_op(i % 3, o, x, y, lat);
            e = model(o, x, y);
            check_result(i % 3, $sformatf("rand[%0d] op=%b a=%h b=%h", i, o, x, y), e, lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
